// File: rtl/rib_pkg.sv
// Shared RIB bus widths, timeout response word and the packed command bundle.
// Latency: n/a (types and constants only). Backpressure: n/a.
package rib_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;
  localparam int RIB_MASK_W = 4;

  localparam logic [RIB_DATA_W-1:0] RIB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [RIB_ADDR_W-1:0] addr;
    logic                  wrcs;
    logic [RIB_MASK_W-1:0] mask;
    logic [RIB_DATA_W-1:0] wdata;
  } rib_cmd_t;

  // Index width for n items, never narrower than one bit.
  function automatic int rib_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rib_id_fifo.sv
// In-order FIFO of master IDs for accepted, still-unanswered transactions.
// Latency: push visible at head one cycle later. Backpressure: push ignored when full, pop ignored when empty.
module rib_id_fifo
  import rib_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = rib_id_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Round-robin RIB arbiter: shares one slave among MASTERS, routing responses back in order via an ID FIFO.
// Latency: zero-cycle grant and response routing (combinational). Backpressure: slave gnt=0 locks the selection; full ID FIFO drops o_ribs_req; head master rdy gates o_ribs_rdy.
// Optional macro RIB_ARB_TIMEOUT_EN adds a response watchdog that forces a DEAD_BEEF reply after TIMEOUT_CYC.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int MASTERS     = 2,
  parameter int OUTSTANDING = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [RIB_ADDR_W*MASTERS-1:0] i_ribm_addr,
  input  logic [MASTERS-1:0]            i_ribm_wrcs,
  input  logic [RIB_MASK_W*MASTERS-1:0] i_ribm_mask,
  input  logic [RIB_DATA_W*MASTERS-1:0] i_ribm_wdata,
  output logic [RIB_DATA_W*MASTERS-1:0] o_ribm_rdata,
  input  logic [MASTERS-1:0]            i_ribm_req,
  output logic [MASTERS-1:0]            o_ribm_gnt,
  output logic [MASTERS-1:0]            o_ribm_rsp,
  input  logic [MASTERS-1:0]            i_ribm_rdy,
  output logic [RIB_ADDR_W-1:0]         o_ribs_addr,
  output logic                          o_ribs_wrcs,
  output logic [RIB_MASK_W-1:0]         o_ribs_mask,
  output logic [RIB_DATA_W-1:0]         o_ribs_wdata,
  input  logic [RIB_DATA_W-1:0]         i_ribs_rdata,
  output logic                          o_ribs_req,
  input  logic                          i_ribs_gnt,
  input  logic                          i_ribs_rsp,
  output logic                          o_ribs_rdy
);

  localparam int              IW      = rib_id_w(MASTERS);
  localparam logic [IW-1:0]   LAST_ID = IW'(MASTERS - 1);

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         locked_id;
  logic                  lock;
  logic [IW-1:0]         sel_free;
  logic [IW-1:0]         scan_id;
  logic                  found;
  logic [IW-1:0]         sel;
  rib_cmd_t              sel_cmd;
  rib_cmd_t              out_cmd;
  logic                  accept;
  logic [IW-1:0]         head;
  logic                  head_rdy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  rsp_vld;
  logic [RIB_DATA_W-1:0] rsp_dat;

  function automatic logic [IW-1:0] id_inc(input logic [IW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // First requester at or after the round-robin pointer.
  always_comb begin
    sel_free = rr_ptr;
    found    = 1'b0;
    scan_id  = rr_ptr;
    for (int k = 0; k < MASTERS; k++) begin
      if (!found && i_ribm_req[scan_id]) begin
        found    = 1'b1;
        sel_free = scan_id;
      end
      scan_id = id_inc(scan_id);
    end
  end

  assign sel = lock ? locked_id : sel_free;

  always_comb begin
    sel_cmd = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (sel == IW'(k)) begin
        sel_cmd.addr  = i_ribm_addr[k*RIB_ADDR_W +: RIB_ADDR_W];
        sel_cmd.wrcs  = i_ribm_wrcs[k];
        sel_cmd.mask  = i_ribm_mask[k*RIB_MASK_W +: RIB_MASK_W];
        sel_cmd.wdata = i_ribm_wdata[k*RIB_DATA_W +: RIB_DATA_W];
      end
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  assign out_cmd      = i_rst ? sel_cmd : '0;
  assign o_ribs_addr  = out_cmd.addr;
  assign o_ribs_wrcs  = out_cmd.wrcs;
  assign o_ribs_mask  = out_cmd.mask;
  assign o_ribs_wdata = out_cmd.wdata;

  assign o_ribs_req = i_rst & (|i_ribm_req) & ~fifo_full;
  assign accept     = o_ribs_req & i_ribs_gnt;

  always_comb begin
    o_ribm_gnt = '0;
    for (int k = 0; k < MASTERS; k++) o_ribm_gnt[k] = accept && (sel == IW'(k));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr    <= '0;
      lock      <= 1'b0;
      locked_id <= '0;
    end else if (accept) begin
      rr_ptr <= id_inc(sel);
      lock   <= 1'b0;
    end else if (o_ribs_req) begin
      lock      <= 1'b1;
      locked_id <= sel;
    end
  end

  rib_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .push     (accept),
    .push_dat (sel),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_rdy   = i_ribm_rdy[head];
  // With nothing outstanding, any slave response is stray and is drained.
  assign o_ribs_rdy = i_rst & (fifo_empty | head_rdy);

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wdog;
  logic          timed_out;
  logic          force_rsp;

  assign timed_out = ~fifo_empty & (wdog == WW'(TIMEOUT_CYC));
  assign force_rsp = timed_out & ~i_ribs_rsp;
  assign rsp_vld   = ~fifo_empty & (i_ribs_rsp | force_rsp);
  assign rsp_dat   = force_rsp ? RIB_TIMEOUT_DATA : i_ribs_rdata;
  assign pop       = rsp_vld & head_rdy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wdog <= '0;
    end else if (pop || (timed_out && i_ribs_rsp)) begin
      wdog <= '0;
    end else if (!fifo_empty && !timed_out) begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign rsp_vld        = i_ribs_rsp & ~fifo_empty;
  assign rsp_dat        = i_ribs_rdata;
  assign pop            = rsp_vld & head_rdy;
`endif

  always_comb begin
    o_ribm_rsp = '0;
    for (int k = 0; k < MASTERS; k++) o_ribm_rsp[k] = i_rst && rsp_vld && (head == IW'(k));
  end

  assign o_ribm_rdata = {MASTERS{i_rst ? rsp_dat : {RIB_DATA_W{1'b0}}}};

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rib_arbiter;

  localparam int M   = 2;
  localparam int OUT = 2;
  localparam int T   = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [63:0]   i_ribm_addr;
  logic [1:0]    i_ribm_wrcs;
  logic [7:0]    i_ribm_mask;
  logic [63:0]   i_ribm_wdata;
  logic [63:0]   o_ribm_rdata;
  logic [1:0]    i_ribm_req;
  logic [1:0]    o_ribm_gnt;
  logic [1:0]    o_ribm_rsp;
  logic [1:0]    i_ribm_rdy;
  logic [31:0]   o_ribs_addr;
  logic          o_ribs_wrcs;
  logic [3:0]    o_ribs_mask;
  logic [31:0]   o_ribs_wdata;
  logic [31:0]   i_ribs_rdata;
  logic          o_ribs_req;
  logic          i_ribs_gnt;
  logic          i_ribs_rsp;
  logic          o_ribs_rdy;

  int checks = 0;
  int errors = 0;

  rib_arbiter #(.MASTERS(M), .OUTSTANDING(OUT), .TIMEOUT_CYC(T)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ribm_addr(i_ribm_addr), .i_ribm_wrcs(i_ribm_wrcs), .i_ribm_mask(i_ribm_mask),
    .i_ribm_wdata(i_ribm_wdata), .o_ribm_rdata(o_ribm_rdata), .i_ribm_req(i_ribm_req),
    .o_ribm_gnt(o_ribm_gnt), .o_ribm_rsp(o_ribm_rsp), .i_ribm_rdy(i_ribm_rdy),
    .o_ribs_addr(o_ribs_addr), .o_ribs_wrcs(o_ribs_wrcs), .o_ribs_mask(o_ribs_mask),
    .o_ribs_wdata(o_ribs_wdata), .i_ribs_rdata(i_ribs_rdata), .o_ribs_req(o_ribs_req),
    .i_ribs_gnt(i_ribs_gnt), .i_ribs_rsp(i_ribs_rsp), .o_ribs_rdy(o_ribs_rdy)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state: round-robin pointer, pending lock, queue of outstanding master IDs.
  int          m_rr;
  bit          m_lock;
  int          m_lock_id;
  int          m_q[$];
  int          m_wait;
  bit          e_req;
  int          e_sel;
  logic [1:0]  e_gnt;
  logic [1:0]  e_rsp;
  logic        e_rdy;
  logic [31:0] e_rdata;
  bit          e_pop;

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lock_id = 0; m_wait = 0;
    m_q.delete();
  endtask

  task automatic model_eval();
    int h;
    e_req = (i_ribm_req != 2'b00) && (m_q.size() < OUT);
    if (m_lock) e_sel = m_lock_id;
    else begin
      e_sel = m_rr;
      for (int k = M - 1; k >= 0; k--)
        if (i_ribm_req[(m_rr + k) % M]) e_sel = (m_rr + k) % M;
    end
    e_gnt   = (e_req && i_ribs_gnt) ? 2'(1 << e_sel) : 2'b00;
    e_rsp   = 2'b00;
    e_rdy   = 1'b1;
    e_rdata = i_ribs_rdata;
    e_pop   = 0;
    if (m_q.size() > 0) begin
      h     = m_q[0];
      e_rdy = i_ribm_rdy[h];
      if (i_ribs_rsp) begin
        e_rsp = 2'(1 << h);
        e_pop = i_ribm_rdy[h];
      end
`ifdef RIB_ARB_TIMEOUT_EN
      else if (m_wait == T) begin
        e_rsp   = 2'(1 << h);
        e_rdata = 32'hDEAD_BEEF;
        e_pop   = i_ribm_rdy[h];
      end
`endif
    end
  endtask

  task automatic model_commit();
`ifdef RIB_ARB_TIMEOUT_EN
    if (e_pop || (m_q.size() > 0 && m_wait == T && i_ribs_rsp)) m_wait = 0;
    else if (m_q.size() > 0 && m_wait < T) m_wait++;
`endif
    if (e_pop) void'(m_q.pop_front());
    if (e_gnt != 2'b00) begin
      m_q.push_back(e_sel);
      m_rr   = (e_sel + 1) % M;
      m_lock = 0;
    end else if (e_req) begin
      m_lock    = 1;
      m_lock_id = e_sel;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ribm_addr = '0; i_ribm_wrcs = '0; i_ribm_mask = '0; i_ribm_wdata = '0;
    i_ribm_req = '0; i_ribm_rdy = 2'b11; i_ribs_rdata = '0; i_ribs_gnt = 0; i_ribs_rsp = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 0;
    tick(); tick();
    i_rst = 1;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 0;
    i_ribm_req = 2'b11; i_ribs_gnt = 1; i_ribs_rsp = 1;
    tick(); #2;
    checks++; if (o_ribm_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", o_ribm_gnt); end
    checks++; if (o_ribm_rsp !== 2'b00) begin errors++; $display("FAIL reset_rsp got=%b exp=00", o_ribm_rsp); end
    checks++; if (o_ribs_req !== 1'b0) begin errors++; $display("FAIL reset_ribs_req got=%b exp=0", o_ribs_req); end
    checks++; if (o_ribs_rdy !== 1'b0) begin errors++; $display("FAIL reset_ribs_rdy got=%b exp=0", o_ribs_rdy); end
    clear_inputs();
    i_rst = 1;
    tick(); #2;
    checks++; if (o_ribs_rdy !== 1'b1) begin errors++; $display("FAIL idle_ribs_rdy got=%b exp=1", o_ribs_rdy); end
  endtask

  task automatic test_single();
    do_reset();
    i_ribm_addr[31:0] = 32'hF000_0004; i_ribm_wrcs = 2'b01; i_ribm_req = 2'b01; i_ribs_gnt = 1;
    #2;
    checks++; if (o_ribm_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", o_ribm_gnt); end
    checks++; if (o_ribs_addr !== 32'hF000_0004) begin errors++; $display("FAIL single_addr got=%h exp=f0000004", o_ribs_addr); end
    checks++; if (o_ribs_wrcs !== 1'b1) begin errors++; $display("FAIL single_wrcs got=%b exp=1", o_ribs_wrcs); end
    tick();
    i_ribm_req = 2'b00; i_ribs_gnt = 0;
    tick();
    i_ribs_rsp = 1; i_ribs_rdata = 32'h1234; i_ribm_rdy = 2'b01;
    #2;
    checks++; if (o_ribm_rsp !== 2'b01) begin errors++; $display("FAIL single_rsp got=%b exp=01", o_ribm_rsp); end
    checks++; if (o_ribm_rdata !== {2{32'h1234}}) begin errors++; $display("FAIL single_rdata got=%h exp=%h", o_ribm_rdata, {2{32'h1234}}); end
    tick();
    i_ribs_rdata = 32'h9999;
    #2;
    checks++; if (o_ribm_rsp !== 2'b00 || o_ribs_rdy !== 1'b1) begin errors++; $display("FAIL single_empty_after rsp=%b rdy=%b exp rsp=00 rdy=1", o_ribm_rsp, o_ribs_rdy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    i_ribm_req = 2'b11; i_ribs_gnt = 1; i_ribs_rsp = 1; i_ribm_rdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      checks++; if (o_ribm_gnt !== exp) begin errors++; $display("FAIL rr_alternate[%0d] got=%b exp=%b", i, o_ribm_gnt, exp); end
      tick();
    end
    i_ribm_req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (o_ribm_gnt !== 2'b01) begin errors++; $display("FAIL rr_solo[%0d] got=%b exp=01", i, o_ribm_gnt); end
      tick();
    end
  endtask

  task automatic test_lock();
    do_reset();
    i_ribm_addr = {32'h1111_0000, 32'h2222_0000};
    i_ribm_req = 2'b10; i_ribs_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (o_ribs_addr !== 32'h1111_0000 || o_ribm_gnt !== 2'b00) begin errors++; $display("FAIL lock_hold[%0d] addr=%h gnt=%b exp addr=11110000 gnt=00", i, o_ribs_addr, o_ribm_gnt); end
      tick();
      i_ribm_req = 2'b11;
    end
    i_ribs_gnt = 1;
    #2;
    checks++; if (o_ribm_gnt !== 2'b10) begin errors++; $display("FAIL lock_grant got=%b exp=10", o_ribm_gnt); end
    tick();
    #2;
    checks++; if (o_ribm_gnt !== 2'b01) begin errors++; $display("FAIL lock_next got=%b exp=01", o_ribm_gnt); end
    tick();
  endtask

  task automatic test_full_order();
    do_reset();
    i_ribm_req = 2'b01; i_ribs_gnt = 1;
    #2;
    checks++; if (o_ribm_gnt !== 2'b01) begin errors++; $display("FAIL full_acc0 got=%b exp=01", o_ribm_gnt); end
    tick();
    i_ribm_req = 2'b10;
    #2;
    checks++; if (o_ribm_gnt !== 2'b10) begin errors++; $display("FAIL full_acc1 got=%b exp=10", o_ribm_gnt); end
    tick();
    i_ribm_req = 2'b01;
    #2;
    checks++; if (o_ribs_req !== 1'b0 || o_ribm_gnt !== 2'b00) begin errors++; $display("FAIL full_block req=%b gnt=%b exp req=0 gnt=00", o_ribs_req, o_ribm_gnt); end
    tick();
    i_ribs_rsp = 1; i_ribs_rdata = 32'hA;
    #2;
    checks++; if (o_ribm_rsp !== 2'b01 || o_ribm_rdata[31:0] !== 32'hA) begin errors++; $display("FAIL full_rsp0 rsp=%b data=%h exp rsp=01 data=a", o_ribm_rsp, o_ribm_rdata[31:0]); end
    checks++; if (o_ribs_req !== 1'b0) begin errors++; $display("FAIL full_block_on_pop got=%b exp=0", o_ribs_req); end
    tick();
    i_ribs_rdata = 32'hB;
    #2;
    checks++; if (o_ribm_rsp !== 2'b10 || o_ribm_rdata[63:32] !== 32'hB) begin errors++; $display("FAIL full_rsp1 rsp=%b data=%h exp rsp=10 data=b", o_ribm_rsp, o_ribm_rdata[63:32]); end
    checks++; if (o_ribs_req !== 1'b1 || o_ribm_gnt !== 2'b01) begin errors++; $display("FAIL full_reassert req=%b gnt=%b exp req=1 gnt=01", o_ribs_req, o_ribm_gnt); end
    tick();
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    i_ribm_req = 2'b01; i_ribs_gnt = 1;
    tick();
    i_ribm_req = 2'b00; i_ribs_gnt = 0; i_ribs_rsp = 1; i_ribs_rdata = 32'h5; i_ribm_rdy = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (o_ribs_rdy !== 1'b0 || o_ribm_rsp !== 2'b01) begin errors++; $display("FAIL bp_hold[%0d] rdy=%b rsp=%b exp rdy=0 rsp=01", i, o_ribs_rdy, o_ribm_rsp); end
      tick();
    end
    #1;
    i_rst = 0; i_ribm_req = 2'b01; i_ribs_gnt = 1;
    #1;
    checks++; if (o_ribm_rsp !== 2'b00 || o_ribs_rdy !== 1'b0 || o_ribs_req !== 1'b0 || o_ribm_gnt !== 2'b00 || o_ribm_rdata !== 64'd0) begin
      errors++; $display("FAIL async_reset rsp=%b rdy=%b req=%b gnt=%b rdata=%h exp all zero", o_ribm_rsp, o_ribs_rdy, o_ribs_req, o_ribm_gnt, o_ribm_rdata); end
    tick();
    i_rst = 1; i_ribm_req = 2'b00; i_ribs_gnt = 0; i_ribs_rsp = 1; i_ribs_rdata = 32'h77; i_ribm_rdy = 2'b00;
    #2;
    checks++; if (o_ribs_rdy !== 1'b1 || o_ribm_rsp !== 2'b00) begin errors++; $display("FAIL stray_drain rdy=%b rsp=%b exp rdy=1 rsp=00", o_ribs_rdy, o_ribm_rsp); end
    tick();
    model_reset();
  endtask

`ifdef RIB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    i_ribm_req = 2'b10; i_ribs_gnt = 1;
    tick();
    i_ribm_req = 2'b00; i_ribs_gnt = 0; i_ribm_rdy = 2'b10; i_ribs_rdata = 32'h5555;
    n = 0;
    while (n < 40) begin
      #2;
      if (o_ribm_rsp != 2'b00) break;
      tick();
      n++;
    end
    checks++; if (n != T) begin errors++; $display("FAIL timeout_cycle got=%0d exp=%0d", n, T); end
    checks++; if (o_ribm_rsp !== 2'b10 || o_ribm_rdata[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_rsp rsp=%b data=%h exp rsp=10 data=deadbeef", o_ribm_rsp, o_ribm_rdata[63:32]); end
    tick();
    i_ribs_rsp = 1;
    #2;
    checks++; if (o_ribm_rsp !== 2'b00 || o_ribs_rdy !== 1'b1) begin errors++; $display("FAIL timeout_empty rsp=%b rdy=%b exp rsp=00 rdy=1", o_ribm_rsp, o_ribs_rdy); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [1:0] last_gnt;
    do_reset();
    last_gnt = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < M; k++) begin
        if (!(i_ribm_req[k] && !last_gnt[k])) begin
          i_ribm_req[k] = ($urandom_range(0, 2) != 0);
          i_ribm_addr[k*32 +: 32]  = $urandom;
          i_ribm_wdata[k*32 +: 32] = $urandom;
          i_ribm_mask[k*4 +: 4]    = 4'($urandom);
          i_ribm_wrcs[k]           = 1'($urandom);
        end
        i_ribm_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      i_ribs_gnt   = ($urandom_range(0, 3) != 0);
      i_ribs_rsp   = 1'($urandom);
      i_ribs_rdata = $urandom;
      #2;
      model_eval();
      checks++; if (o_ribs_req !== e_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, o_ribs_req, e_req); end
      checks++; if (o_ribm_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, o_ribm_gnt, e_gnt); end
      checks++; if (o_ribm_rsp !== e_rsp) begin errors++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, o_ribm_rsp, e_rsp); end
      checks++; if (o_ribs_rdy !== e_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, o_ribs_rdy, e_rdy); end
      if (e_rsp != 2'b00) begin
        checks++; if (o_ribm_rdata !== {2{e_rdata}}) begin errors++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, o_ribm_rdata, {2{e_rdata}}); end
      end
      if (e_req) begin
        checks++;
        if (o_ribs_addr !== i_ribm_addr[e_sel*32 +: 32] || o_ribs_wdata !== i_ribm_wdata[e_sel*32 +: 32] ||
            o_ribs_mask !== i_ribm_mask[e_sel*4 +: 4] || o_ribs_wrcs !== i_ribm_wrcs[e_sel]) begin
          errors++; $display("FAIL rnd_cmd c=%0d addr=%h exp_master=%0d exp_addr=%h", c, o_ribs_addr, e_sel, i_ribm_addr[e_sel*32 +: 32]);
        end
      end
      last_gnt = e_gnt;
      model_commit();
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    i_rst = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full_order();
    test_backpressure_reset();
`ifdef RIB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
